// File: rtl/dm_resp_pkg.sv
// Shared types and constants for the data-memory responder: FSM states,
// the MMIO cycle-counter address and the wait-state counter width.
package dm_resp_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    localparam logic [31:0] MMIO_CNT_ADDR = 32'h0000_1000;
    localparam int          CNT_W         = 4;

    // Expands a 4-bit byte enable into a 32-bit bit mask.
    function automatic logic [31:0] be_to_mask(input logic [3:0] be);
        logic [31:0] m;
        m = '0;
        for (int i = 0; i < 4; i++) begin
            m[8*i +: 8] = {8{be[i]}};
        end
        return m;
    endfunction

endpackage

// File: rtl/dm_resp_array.sv
// Word RAM, 2^DEPTH_LOG2 x 32, byte-enable write and registered read on one port.
// One access per enabled edge; no reset (contents survive reset), no backpressure.
module dm_resp_array
    import dm_resp_pkg::*;
#(
    parameter int DEPTH_LOG2 = 10
) (
    input  logic                  clk,
    input  logic                  i_en,
    input  logic                  i_we,
    input  logic [DEPTH_LOG2-1:0] i_addr,
    input  logic [31:0]           i_wdata,
    input  logic [3:0]            i_be,
    output logic [31:0]           o_rdata
);

    logic [31:0] r_mem [0:(1<<DEPTH_LOG2)-1];
    logic [31:0] w_mask;

    assign w_mask = be_to_mask(i_be);

    // A store leaves o_rdata untouched so the last load result stays visible.
    always_ff @(posedge clk) begin
        if (i_en) begin
            if (i_we) begin
                r_mem[i_addr] <= (r_mem[i_addr] & ~w_mask) | (i_wdata & w_mask);
            end else begin
                o_rdata <= r_mem[i_addr];
            end
        end
    end

endmodule

// File: rtl/dm_responder.sv
// Multi-cycle data-memory responder; optional DM_MMIO_EN maps a cycle counter at 0x1000.
// Latency: response valid in the (WAIT_CYCLES+1)th cycle after the accept edge.
// Backpressure: one request in flight; response held until rsp_ready, req_ready low meanwhile.
module dm_responder
    import dm_resp_pkg::*;
#(
    parameter int DEPTH_LOG2  = 10,
    parameter int WAIT_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [3:0]  req_be,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err
);

    localparam logic [CNT_W-1:0] LP_CNT_INIT =
        (WAIT_CYCLES == 0) ? '0 : CNT_W'(WAIT_CYCLES - 1);

    state_t           r_state;
    state_t           w_state_nxt;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_nxt;

    logic             r_we;
    logic [31:0]      r_addr;
    logic [31:0]      r_wdata;
    logic [3:0]       r_be;
    logic [31:0]      r_rdata;
    logic             r_err;
    logic             r_rd_mem;

    logic             w_accept;
    logic             w_commit;
    logic             w_c_we;
    logic [31:0]      w_c_addr;
    logic [31:0]      w_c_wdata;
    logic [3:0]       w_c_be;
    logic             w_aligned;
    logic             w_in_range;
    logic             w_mmio_hit;
    logic             w_mmio_ld;
    logic [31:0]      w_mmio_rdata;
    logic             w_err;
    logic             w_arr_en;
    logic [31:0]      w_arr_rdata;

    assign w_accept = (r_state == IDLE) && req_valid;

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_commit    = 1'b0;
        case (r_state)
            IDLE: begin
                if (req_valid) begin
                    if (WAIT_CYCLES == 0) begin
                        w_state_nxt = RESP;
                        w_commit    = 1'b1;
                    end else begin
                        w_state_nxt = WAIT;
                        w_cnt_nxt   = LP_CNT_INIT;
                    end
                end
            end
            WAIT: begin
                if (r_cnt == '0) begin
                    w_state_nxt = RESP;
                    w_commit    = 1'b1;
                end else begin
                    w_cnt_nxt = r_cnt - 1'b1;
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    w_state_nxt = IDLE;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    // With zero wait states the commit coincides with acceptance, so the
    // request fields come straight from the ports instead of the capture regs.
    assign w_c_we    = (r_state == IDLE) ? req_we    : r_we;
    assign w_c_addr  = (r_state == IDLE) ? req_addr  : r_addr;
    assign w_c_wdata = (r_state == IDLE) ? req_wdata : r_wdata;
    assign w_c_be    = (r_state == IDLE) ? req_be    : r_be;

    assign w_aligned  = (w_c_addr[1:0] == 2'b00);
    assign w_in_range = ((w_c_addr >> (DEPTH_LOG2 + 2)) == 32'd0);

`ifdef DM_MMIO_EN
    logic [31:0] r_cyc;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_cyc <= '0;
        end else begin
            r_cyc <= r_cyc + 32'd1;
        end
    end

    assign w_mmio_rdata = r_cyc;
    assign w_mmio_hit   = !w_in_range && (w_c_addr == MMIO_CNT_ADDR);
`else
    assign w_mmio_rdata = '0;
    assign w_mmio_hit   = 1'b0;
`endif

    // The counter is read-only: a store to it falls through to the range error.
    assign w_mmio_ld = w_mmio_hit && !w_c_we;
    assign w_err     = !w_aligned || (!w_in_range && !w_mmio_ld);
    assign w_arr_en  = w_commit && !w_err && w_in_range;

    dm_resp_array #(
        .DEPTH_LOG2 (DEPTH_LOG2)
    ) u_array (
        .clk     (clk),
        .i_en    (w_arr_en),
        .i_we    (w_c_we),
        .i_addr  (w_c_addr[DEPTH_LOG2+1:2]),
        .i_wdata (w_c_wdata),
        .i_be    (w_c_be),
        .o_rdata (w_arr_rdata)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state  <= IDLE;
            r_cnt    <= '0;
            r_we     <= 1'b0;
            r_addr   <= '0;
            r_wdata  <= '0;
            r_be     <= '0;
            r_rdata  <= '0;
            r_err    <= 1'b0;
            r_rd_mem <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            if (w_accept) begin
                r_we    <= req_we;
                r_addr  <= req_addr;
                r_wdata <= req_wdata;
                r_be    <= req_be;
            end
            if (w_commit) begin
                r_err    <= w_err;
                r_rd_mem <= w_arr_en && !w_c_we;
                r_rdata  <= w_mmio_ld ? w_mmio_rdata : '0;
            end
        end
    end

    assign req_ready = (r_state == IDLE);
    assign rsp_valid = (r_state == RESP);
    assign rsp_rdata = r_rd_mem ? w_arr_rdata : r_rdata;
    assign rsp_err   = r_err;

endmodule

// File: tb/tb_dm_responder.sv
// Scoreboard bench for dm_responder: directed requests push expected responses,
// a negedge monitor pops and compares, and also checks latency and hold stability.
module tb_dm_responder;

    localparam int W  = 2;
    localparam int DL = 10;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_we = 1'b0;
    logic [31:0] req_addr = '0;
    logic [31:0] req_wdata = '0;
    logic [3:0]  req_be = '0;
    logic        rsp_valid;
    logic        rsp_ready = 1'b1;
    logic [31:0] rsp_rdata;
    logic        rsp_err;

    always #5 clk = ~clk;

    dm_responder #(
        .DEPTH_LOG2  (DL),
        .WAIT_CYCLES (W)
    ) dut (
        .clk       (clk),
        .rst       (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_we    (req_we),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .req_be    (req_be),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_rdata (rsp_rdata),
        .rsp_err   (rsp_err)
    );

    // kind 0: exact rdata; 1: record rdata as counter base; 2: rdata - base must equal expected
    typedef struct {
        logic [31:0] rdata;
        logic        err;
        int          kind;
    } exp_t;

    exp_t        sb_q[$];
    string       nm_q[$];
    int          n_cmp = 0;
    int          n_bad = 0;
    int          cyc = 0;
    int          acc_cyc = 0;
    logic [31:0] mmio_base = '0;
    logic [31:0] prev_rdata = '0;
    logic        prev_vld = 1'b0;
    logic        prev_err = 1'b0;
    logic        chk_idle = 1'b0;
    exp_t        mon_e;
    string       mon_nm;

    function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endfunction

    always @(posedge clk) cyc++;

    always @(negedge clk) begin
        if (!rst_n) begin
            prev_vld = 1'b0;
            chk_idle = 1'b0;
        end else begin
            if (chk_idle) begin
                chk("ready_after_hs", {30'd0, req_ready, rsp_valid}, 32'h2);
                chk_idle = 1'b0;
            end
            if (req_valid && req_ready) acc_cyc = cyc;
            if (rsp_valid && !prev_vld) chk("latency", cyc - acc_cyc, W + 1);
            if (rsp_valid && prev_vld) begin
                chk("hold_rdata", rsp_rdata, prev_rdata);
                chk("hold_err_rdy", {30'd0, rsp_err, req_ready}, {30'd0, prev_err, 1'b0});
            end
            if (rsp_valid && rsp_ready) begin
                if (sb_q.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL unexpected_rsp: got rdata 0x%08h, expected no response", rsp_rdata);
                end else begin
                    mon_e  = sb_q.pop_front();
                    mon_nm = nm_q.pop_front();
                    chk({mon_nm, "_err"}, {31'd0, rsp_err}, {31'd0, mon_e.err});
                    case (mon_e.kind)
                        1:       mmio_base = rsp_rdata;
                        2:       chk({mon_nm, "_delta"}, rsp_rdata - mmio_base, mon_e.rdata);
                        default: chk({mon_nm, "_rdata"}, rsp_rdata, mon_e.rdata);
                    endcase
                end
                chk_idle = 1'b1;
            end
            prev_vld   = rsp_valid;
            prev_rdata = rsp_rdata;
            prev_err   = rsp_err;
        end
    end

    // Called just after a rising edge; returns just after the response handshake edge.
    task automatic do_req(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                          input logic [3:0] be, input logic [31:0] er, input logic ee,
                          input int kind, input string name);
        exp_t e;
        int   t;
        e.rdata = er;
        e.err   = ee;
        e.kind  = kind;
        sb_q.push_back(e);
        nm_q.push_back(name);
        t = 0;
        while (!req_ready && t < 50) begin
            @(posedge clk);
            #1;
            t++;
        end
        req_valid = 1'b1;
        req_we    = we;
        req_addr  = addr;
        req_wdata = wdata;
        req_be    = be;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        req_we    = ~we;
        req_addr  = $urandom;
        req_wdata = $urandom;
        req_be    = 4'($urandom);
        t = 0;
        while (!(rsp_valid && rsp_ready) && t < 60) begin
            @(negedge clk);
            t++;
        end
        if (t >= 60) begin
            n_cmp++;
            n_bad++;
            $display("FAIL %s_timeout: got no response in %0d cycles, expected one", name, t);
        end else begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic chk_reset_outputs(input string name);
        chk({name, "_req_ready"}, {31'd0, req_ready}, 32'd1);
        chk({name, "_rsp_valid"}, {31'd0, rsp_valid}, 32'd0);
        chk({name, "_rsp_rdata"}, rsp_rdata, 32'd0);
        chk({name, "_rsp_err"},   {31'd0, rsp_err},   32'd0);
    endtask

    initial begin
        int t;
        #2 rst_n = 1'b0;
        #1 chk_reset_outputs("por");
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        do_req(1'b1, 32'h10, 32'hDEADBEEF, 4'hF, 32'h0,        1'b0, 0, "st_10");
        do_req(1'b0, 32'h10, 32'h0,        4'h0, 32'hDEADBEEF, 1'b0, 0, "ld_10");
        do_req(1'b1, 32'h20, 32'h11223344, 4'hF, 32'h0,        1'b0, 0, "st_20");
        do_req(1'b1, 32'h20, 32'hAABBCCDD, 4'h5, 32'h0,        1'b0, 0, "st_20_be5");
        do_req(1'b0, 32'h20, 32'h0,        4'h0, 32'h11BB33DD, 1'b0, 0, "ld_20");
        do_req(1'b1, 32'h20, 32'hFFFFFFFF, 4'h0, 32'h0,        1'b0, 0, "st_20_be0");
        do_req(1'b0, 32'h20, 32'h0,        4'hF, 32'h11BB33DD, 1'b0, 0, "ld_20_again");
        do_req(1'b1, 32'h0,  32'h55AA55AA, 4'hF, 32'h0,        1'b0, 0, "st_0");
        do_req(1'b0, 32'h22, 32'h0,        4'h0, 32'h0,        1'b1, 0, "ld_misalign");
        do_req(1'b1, 32'h2000, 32'h0BADBAD0, 4'hF, 32'h0,      1'b1, 0, "st_oor");
        do_req(1'b1, 32'h02, 32'h0BADBAD1, 4'hF, 32'h0,        1'b1, 0, "st_misalign");
        do_req(1'b0, 32'h0,  32'h0,        4'h0, 32'h55AA55AA, 1'b0, 0, "ld_0");
        do_req(1'b1, 32'hFFC, 32'hCAFEF00D, 4'hF, 32'h0,       1'b0, 0, "st_top");
        do_req(1'b0, 32'hFFC, 32'h0,       4'h0, 32'hCAFEF00D, 1'b0, 0, "ld_top");

        rsp_ready = 1'b0;
        fork
            do_req(1'b0, 32'h10, 32'h0, 4'h0, 32'hDEADBEEF, 1'b0, 0, "ld_bp");
            begin : bp_release
                t = 0;
                while (!rsp_valid && t < 50) begin
                    @(negedge clk);
                    t++;
                end
                repeat (5) @(posedge clk);
                #1;
                chk("bp_valid_held", {30'd0, rsp_valid, req_ready}, 32'h2);
                rsp_ready = 1'b1;
            end
        join

        do_req(1'b1, 32'h30, 32'h0BADF00D, 4'hF, 32'h0,        1'b0, 0, "st_30");
        do_req(1'b0, 32'h30, 32'h0,        4'h0, 32'h0BADF00D, 1'b0, 0, "ld_30");
        req_valid = 1'b1;
        req_we    = 1'b1;
        req_addr  = 32'h30;
        req_wdata = 32'h12345678;
        req_be    = 4'hF;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        rst_n     = 1'b0;
        #1 chk_reset_outputs("midrst");
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        do_req(1'b0, 32'h30, 32'h0, 4'h0, 32'h0BADF00D, 1'b0, 0, "ld_30_after_rst");

`ifdef DM_MMIO_EN
        do_req(1'b0, 32'h1000, 32'h0, 4'h0, 32'h0, 1'b0, 1, "mmio_ld0");
        repeat (4) @(posedge clk);
        #1;
        do_req(1'b0, 32'h1000, 32'h0, 4'h0, 32'(4 + W + 2), 1'b0, 2, "mmio_ld1");
        do_req(1'b1, 32'h1000, 32'h1, 4'hF, 32'h0, 1'b1, 0, "mmio_st");
`else
        do_req(1'b0, 32'h1000, 32'h0, 4'h0, 32'h0, 1'b1, 0, "ld_1000_oor");
        do_req(1'b1, 32'h1000, 32'h1, 4'hF, 32'h0, 1'b1, 0, "st_1000_oor");
`endif

        repeat (3) @(posedge clk);
        chk("sb_empty", sb_q.size(), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no end of test by %0t, expected completion", $time);
        $fatal(1, "watchdog expired");
    end

endmodule
